// File: rtl/tiny_rv_fetch_queue.sv
// Decoupled instruction prefetcher with a DEPTH-entry {pc, inst} queue.
// Define TINY_RV_FQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module tiny_rv_fetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 4,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_redirect,
  input  logic [XLEN-1:0]          i_redirect_pc,
  output logic                     o_imem_req_valid,
  input  logic                     i_imem_req_ready,
  output logic [XLEN-1:0]          o_imem_req_addr,
  input  logic                     i_imem_rsp_valid,
  input  logic [31:0]              i_imem_rsp_data,
  output logic                     o_fetch_valid,
  input  logic                     i_fetch_ready,
  output logic [XLEN-1:0]          o_fetch_pc,
  output logic [31:0]              o_fetch_inst,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);

  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] tgt_pc;
  logic [XLEN-1:0] q_pc [DEPTH];
  logic [31:0]     q_inst [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   in_flight;
  logic [CW-1:0]   discard;
  logic [CW:0]     credit;
  logic            req_fire;
  logic            rsp_fresh;
  logic            rsp_drop;
  logic            head_valid;
  logic            byp;
  logic            q_push;
  logic            q_pop;

  assign tgt_pc   = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign credit   = {1'b0, count} + {1'b0, in_flight};

  // Credits reserve a slot for every in-flight response, so a push never overflows.
  assign o_imem_req_valid = i_reset & ~i_redirect &
                            (credit < DEPTH_C) &
                            (in_flight < MAXO_C);
  assign o_imem_req_addr  = req_pc;

  assign req_fire   = o_imem_req_valid & i_imem_req_ready;
  assign rsp_fresh  = i_imem_rsp_valid & (discard == '0) & ~i_redirect;
  assign rsp_drop   = i_imem_rsp_valid & (discard != '0);
  assign head_valid = (count != '0);
  assign q_pop      = head_valid & i_fetch_ready;

`ifdef TINY_RV_FQ_BYPASS_EN
  assign byp = rsp_fresh & ~head_valid;
`else
  assign byp = 1'b0;
`endif

  assign q_push = rsp_fresh & ~(byp & i_fetch_ready);

  assign o_fetch_valid = head_valid | byp;
  assign o_fetch_pc    = head_valid ? q_pc[rd_ptr]   :
                         byp        ? rsp_pc         : '0;
  assign o_fetch_inst  = head_valid ? q_inst[rd_ptr] :
                         byp        ? i_imem_rsp_data : '0;
  assign o_count       = count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      req_pc    <= RESET_PC;
      rsp_pc    <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      in_flight <= '0;
      discard   <= '0;
    end else begin
      in_flight <= in_flight + CW'(req_fire) - CW'(i_imem_rsp_valid);
      if (i_redirect) begin
        req_pc  <= tgt_pc;
        rsp_pc  <= tgt_pc;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
        // Everything still in flight is stale; a response this cycle is dropped now.
        discard <= in_flight - CW'(i_imem_rsp_valid);
      end else begin
        if (req_fire)  req_pc  <= req_pc + XLEN'(4);
        if (rsp_fresh) rsp_pc  <= rsp_pc + XLEN'(4);
        if (rsp_drop)  discard <= discard - CW'(1);
        if (q_push)    wr_ptr  <= wr_ptr + PW'(1);
        if (q_pop)     rd_ptr  <= rd_ptr + PW'(1);
        count <= count + CW'(q_push) - CW'(q_pop);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (q_push) begin
      q_pc[wr_ptr]   <= rsp_pc;
      q_inst[wr_ptr] <= i_imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_tiny_rv_fetch_queue.sv
// Randomised bench for tiny_rv_fetch_queue: two instances, epoch-tagged memory
// model and an expected-stream queue per instance.
module tb_tiny_rv_fetch_queue;

`ifdef TINY_RV_FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_redir, a_reqv, a_reqr, a_rspv, a_fv, a_fr;
  logic [31:0] a_rpc, a_addr, a_rspd, a_fpc, a_finst;
  logic [2:0]  a_cnt;
  logic        b_redir, b_reqv, b_reqr, b_rspv, b_fv, b_fr;
  logic [31:0] b_rpc, b_addr, b_rspd, b_fpc, b_finst;
  logic [2:0]  b_cnt;

  tiny_rv_fetch_queue dut_a (
    .i_clk(clk), .i_reset(rst_n),
    .i_redirect(a_redir), .i_redirect_pc(a_rpc),
    .o_imem_req_valid(a_reqv), .i_imem_req_ready(a_reqr),
    .o_imem_req_addr(a_addr),
    .i_imem_rsp_valid(a_rspv), .i_imem_rsp_data(a_rspd),
    .o_fetch_valid(a_fv), .i_fetch_ready(a_fr),
    .o_fetch_pc(a_fpc), .o_fetch_inst(a_finst),
    .o_count(a_cnt)
  );

  tiny_rv_fetch_queue #(
    .MAX_OUTSTANDING(1),
    .RESET_PC(32'hFFFF_FFF8)
  ) dut_b (
    .i_clk(clk), .i_reset(rst_n),
    .i_redirect(b_redir), .i_redirect_pc(b_rpc),
    .o_imem_req_valid(b_reqv), .i_imem_req_ready(b_reqr),
    .o_imem_req_addr(b_addr),
    .i_imem_rsp_valid(b_rspv), .i_imem_rsp_data(b_rspd),
    .o_fetch_valid(b_fv), .i_fetch_ready(b_fr),
    .o_fetch_pc(b_fpc), .o_fetch_inst(b_finst),
    .o_count(b_cnt)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          p_frdy, p_mrdy, p_redir;
  int          qh[2], qt[2], mh[2], mt[2], ep[2], lat[2], maxo[2], pops[2];
  logic [31:0] qpc[2][64];
  logic [31:0] maddr[2][64];
  int          mep[2][64];
  int          mdue[2][64];
  logic [31:0] ereq[2];
  logic        d_redir[2], d_mrdy[2], d_rspv[2], d_frdy[2];
  logic [31:0] d_rpc[2], d_rspd[2];
  logic        o_reqv[2], o_fv[2];
  logic [31:0] o_addr[2], o_fpc[2], o_finst[2], o_cnt[2];

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input int k, input string tag,
                     input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL dut%0d %s obs=%h exp=%h cyc=%0d", k, tag, obs, exp, cyc);
    end
  endtask

  task automatic apply();
    a_redir = d_redir[0]; a_rpc = d_rpc[0]; a_reqr = d_mrdy[0];
    a_rspv  = d_rspv[0];  a_rspd = d_rspd[0]; a_fr = d_frdy[0];
    b_redir = d_redir[1]; b_rpc = d_rpc[1]; b_reqr = d_mrdy[1];
    b_rspv  = d_rspv[1];  b_rspd = d_rspd[1]; b_fr = d_frdy[1];
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      d_frdy[k]  = ($urandom_range(99) < p_frdy);
      d_mrdy[k]  = ($urandom_range(99) < p_mrdy);
      d_redir[k] = ($urandom_range(99) < p_redir);
      d_rpc[k]   = $urandom;
      d_rspd[k]  = $urandom;
      d_rspv[k]  = 1'b0;
      if (mh[k] != mt[k] && mdue[k][mh[k]%64] <= cyc) begin
        d_rspv[k] = 1'b1;
        d_rspd[k] = word(maddr[k][mh[k]%64]);
      end
    end
    apply();
  endtask

  task automatic sample_check();
    o_reqv[0] = a_reqv; o_addr[0] = a_addr; o_fv[0] = a_fv;
    o_fpc[0] = a_fpc; o_finst[0] = a_finst; o_cnt[0] = 32'(a_cnt);
    o_reqv[1] = b_reqv; o_addr[1] = b_addr; o_fv[1] = b_fv;
    o_fpc[1] = b_fpc; o_finst[1] = b_finst; o_cnt[1] = 32'(b_cnt);
    for (int k = 0; k < 2; k++) begin
      int          sz, outst, hi;
      logic        fresh, bp, fv, rv;
      logic [31:0] hpc;
      sz    = qt[k] - qh[k];
      outst = mt[k] - mh[k];
      hi    = mh[k] % 64;
      fresh = d_rspv[k] && (mep[k][hi] == ep[k]) && !d_redir[k];
      bp    = BYP && (sz == 0) && fresh;
      fv    = (sz != 0) || bp;
      hpc   = (sz != 0) ? qpc[k][qh[k]%64] : maddr[k][hi];
      rv    = !d_redir[k] && (sz + outst < 4) && (outst < maxo[k]);
      chk(k, "count", o_cnt[k], 32'(sz));
      chk(k, "fetch_valid", 32'(o_fv[k]), 32'(fv));
      chk(k, "req_valid", 32'(o_reqv[k]), 32'(rv));
      if (fv) begin
        chk(k, "fetch_pc", o_fpc[k], hpc);
        chk(k, "fetch_inst", o_finst[k], word(hpc));
      end
      if (rv) chk(k, "req_addr", o_addr[k], ereq[k]);
      if (fv && d_frdy[k]) begin
        pops[k]++;
        if (sz != 0) qh[k]++;
      end
      if (fresh && !(bp && d_frdy[k])) begin
        qpc[k][qt[k]%64] = maddr[k][hi];
        qt[k]++;
      end
      if (d_redir[k]) begin
        qh[k]   = qt[k];
        ep[k]++;
        ereq[k] = d_rpc[k] & ~32'h3;
      end
      if (rv && d_mrdy[k]) begin
        maddr[k][mt[k]%64] = ereq[k];
        mep[k][mt[k]%64]   = ep[k];
        mdue[k][mt[k]%64]  = cyc + lat[k];
        mt[k]++;
        ereq[k] += 32'd4;
      end
      if (d_rspv[k]) mh[k]++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive();
      @(negedge clk);
      sample_check();
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      qh[k] = 0; qt[k] = 0; mh[k] = 0; mt[k] = 0; ep[k] = 0; pops[k] = 0;
      d_redir[k] = 0; d_rpc[k] = 0; d_mrdy[k] = 0;
      d_rspv[k] = 0; d_rspd[k] = 0; d_frdy[k] = 0;
    end
    maxo[0] = 4; maxo[1] = 1;
    lat[0]  = 1; lat[1]  = 2;
    ereq[0] = 32'h0; ereq[1] = 32'hFFFF_FFF8;
    rst_n = 1'b0;
    apply();
    #12;
    chk(0, "rst_reqv", 32'(a_reqv), 32'd0);
    chk(0, "rst_fv", 32'(a_fv), 32'd0);
    chk(0, "rst_cnt", 32'(a_cnt), 32'd0);
    chk(0, "rst_pc", a_fpc, 32'd0);
    chk(0, "rst_inst", a_finst, 32'd0);
    chk(0, "rst_addr", a_addr, 32'h0);
    chk(1, "rst_reqv", 32'(b_reqv), 32'd0);
    chk(1, "rst_addr", b_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    p_frdy = 100; p_mrdy = 100; p_redir = 0;
    run(40);
    chk(0, "throughput", 32'(pops[0] >= 38), 32'd1);

    p_frdy = 0;
    run(20);
    chk(0, "stall_cnt", 32'(a_cnt), 32'd4);
    chk(0, "stall_reqv", 32'(a_reqv), 32'd0);
    chk(1, "stall_cnt", 32'(b_cnt), 32'd4);

    p_frdy = 100;
    run(12);

    lat[0] = 3; p_frdy = 70; p_mrdy = 80; p_redir = 10;
    run(300);

    lat[0] = 1; p_frdy = 80; p_mrdy = 90; p_redir = 30;
    run(300);

    lat[0] = 2; p_frdy = 50; p_mrdy = 70; p_redir = 5;
    run(300);

    rst_n = 1'b0;
    #1;
    chk(0, "midrst_cnt", 32'(a_cnt), 32'd0);
    chk(0, "midrst_fv", 32'(a_fv), 32'd0);
    chk(0, "midrst_reqv", 32'(a_reqv), 32'd0);
    chk(1, "midrst_cnt", 32'(b_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
